// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory bridge: FSM encoding, abort read data
// and the default timeout budget.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RSP = 3'd2,
    DONE     = 3'd3,
    DRAIN    = 3'd4
  } mem_state_e;

  localparam logic [31:0] ERR_RDATA           = 32'hDEAD_BEEF;
  localparam int          DEFAULT_TIMEOUT_CYC = 64;

endpackage

// File: rtl/data_mem_bridge_if.sv
// req/gnt/rvalid memory bus between the load/store bridge (master) and the
// data memory (slave).
interface data_mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              BusReq_o;
  logic              BusWe_o;
  logic [ADDR_W-1:0] BusAddr_o;
  logic [DATA_W-1:0] BusWData_o;
  logic              BusGnt_i;
  logic              BusRValid_i;
  logic [DATA_W-1:0] BusRData_i;

  modport master (
    output BusReq_o, BusWe_o, BusAddr_o, BusWData_o,
    input  BusGnt_i, BusRValid_i, BusRData_i
  );

  modport slave (
    input  BusReq_o, BusWe_o, BusAddr_o, BusWData_o,
    output BusGnt_i, BusRValid_i, BusRData_i
  );

endinterface

// File: rtl/mem_timeout_cnt.sv
// Clear/enable cycle counter that flags when it reaches TIMEOUT_CYC-1; used to
// bound how long a bus access may stay outstanding.
module mem_timeout_cnt #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int         W      = $clog2(TIMEOUT_CYC);
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q;

  // Clear wins over enable so a new access always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/data_mem_bridge.sv
// Load/store bridge from the single-cycle datapath onto a req/gnt/rvalid bus.
// Optional posted stores are enabled with DMEM_POSTED_WRITE_EN.
module data_mem_bridge
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] Addr_i,
  input  logic [DATA_W-1:0] WData_i,
  output logic [DATA_W-1:0] RData_o,
  output logic              Stall_o,
  output logic              MisalignErr_o,
  output logic              TimeoutErr_o,
  data_mem_bridge_if.master bus
);

  mem_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              terr_q, terr_d;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic              stall;

  logic access, aligned, is_write;

  assign access   = MemRead_i | MemWrite_i;
  assign aligned  = (Addr_i[1:0] == 2'b00);
  assign is_write = MemWrite_i;

  mem_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk   (Clk),
    .rst_n (Rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      terr_q  <= terr_d;
    end
  end

  // A timeout takes precedence over a grant or response arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    terr_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    stall   = 1'b0;

    case (state_q)
      IDLE: begin
        if (access && aligned) begin
          req_d   = 1'b1;
          we_d    = is_write;
          addr_d  = {Addr_i[ADDR_W-1:2], 2'b00};
          wdata_d = WData_i;
          cnt_clr = 1'b1;
`ifdef DMEM_POSTED_WRITE_EN
          if (is_write) begin
            state_d = DRAIN;
          end else begin
            stall   = 1'b1;
            state_d = REQ;
          end
`else
          stall   = 1'b1;
          state_d = REQ;
`endif
        end
      end

      REQ: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        if (cnt_tc) begin
          req_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = DATA_W'(ERR_RDATA);
          end
        end else if (bus.BusGnt_i) begin
          req_d   = 1'b0;
          state_d = we_q ? DONE : WAIT_RSP;
        end
      end

      WAIT_RSP: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        if (cnt_tc) begin
          terr_d  = 1'b1;
          rdata_d = DATA_W'(ERR_RDATA);
          state_d = DONE;
        end else if (bus.BusRValid_i) begin
          rdata_d = bus.BusRData_i;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

`ifdef DMEM_POSTED_WRITE_EN
      // Returns to IDLE rather than DONE so a held CPU access is started, not skipped.
      DRAIN: begin
        stall  = access && aligned;
        cnt_en = 1'b1;
        if (cnt_tc) begin
          req_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = IDLE;
        end else if (bus.BusGnt_i) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
`endif

      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign Stall_o        = stall;
  assign MisalignErr_o  = access & ~aligned;
  assign TimeoutErr_o   = terr_q;
  assign RData_o        = rdata_q;
  assign bus.BusReq_o   = req_q;
  assign bus.BusWe_o    = we_q;
  assign bus.BusAddr_o  = addr_q;
  assign bus.BusWData_o = wdata_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge: per-cycle vector table plus hand-written
// timeout, reset and (with DMEM_POSTED_WRITE_EN) posted-store sequences.
module tb_data_mem_bridge;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [31:0] Addr_i = '0;
  logic [31:0] WData_i = '0;
  logic [31:0] RData_o;
  logic        Stall_o;
  logic        MisalignErr_o;
  logic        TimeoutErr_o;

  int errors = 0;
  int checks = 0;

  data_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  data_mem_bridge #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .MemRead_i     (MemRead_i),
    .MemWrite_i    (MemWrite_i),
    .Addr_i        (Addr_i),
    .WData_i       (WData_i),
    .RData_o       (RData_o),
    .Stall_o       (Stall_o),
    .MisalignErr_o (MisalignErr_o),
    .TimeoutErr_o  (TimeoutErr_o),
    .bus           (bus_if)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] brdata;
    logic        stall;
    logic        mis;
    logic        req;
    logic        we;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic gnt, input logic rvalid,
                              input logic [31:0] brdata, input logic stall, input logic mis,
                              input logic req, input logic we, input logic [31:0] baddr,
                              input logic [31:0] bwdata, input logic [31:0] rdata);
    vec_t v;
    v = '{rd: rd, wr: wr, addr: addr, wdata: wdata, gnt: gnt, rvalid: rvalid,
          brdata: brdata, stall: stall, mis: mis, req: req, we: we, baddr: baddr,
          bwdata: bwdata, rdata: rdata};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge and outputs are sampled 1 unit later.
  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic gnt, input logic rvalid,
                       input logic [31:0] brdata);
    @(posedge Clk);
    #2;
    MemRead_i          = rd;
    MemWrite_i         = wr;
    Addr_i             = addr;
    WData_i            = wdata;
    bus_if.BusGnt_i    = gnt;
    bus_if.BusRValid_i = rvalid;
    bus_if.BusRData_i  = brdata;
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    drive(v.rd, v.wr, v.addr, v.wdata, v.gnt, v.rvalid, v.brdata);
    checkOutput($sformatf("row%0d_stall", idx), 32'(Stall_o), 32'(v.stall));
    checkOutput($sformatf("row%0d_misalign", idx), 32'(MisalignErr_o), 32'(v.mis));
    checkOutput($sformatf("row%0d_busreq", idx), 32'(bus_if.BusReq_o), 32'(v.req));
    checkOutput($sformatf("row%0d_rdata", idx), RData_o, v.rdata);
    checkOutput($sformatf("row%0d_terr", idx), 32'(TimeoutErr_o), 32'd0);
    if (v.req) begin
      checkOutput($sformatf("row%0d_buswe", idx), 32'(bus_if.BusWe_o), 32'(v.we));
      checkOutput($sformatf("row%0d_busaddr", idx), bus_if.BusAddr_o, v.baddr);
      if (v.we) checkOutput($sformatf("row%0d_buswdata", idx), bus_if.BusWData_o, v.bwdata);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int count;
    logic seen;

    bus_if.BusGnt_i    = 1'b0;
    bus_if.BusRValid_i = 1'b0;
    bus_if.BusRData_i  = '0;

    // Zero-wait load at 0x10: grant in the first REQ cycle, response the next.
    vecs.push_back(mk(1,0,32'h10,0, 0,0,0,            1,0,0,0, 0,0, 32'h0));
    vecs.push_back(mk(1,0,32'h10,0, 1,0,0,            1,0,1,0, 32'h10,0, 32'h0));
    vecs.push_back(mk(1,0,32'h10,0, 0,1,32'hCAFEF00D, 1,0,0,0, 0,0, 32'h0));
    vecs.push_back(mk(1,0,32'h10,0, 0,0,0,            0,0,0,0, 0,0, 32'hCAFEF00D));
    vecs.push_back(mk(0,0,32'h0,0,  0,0,0,            0,0,0,0, 0,0, 32'hCAFEF00D));
`ifndef DMEM_POSTED_WRITE_EN
    // Store at 0x20 granted in the fourth REQ cycle; stray rvalid must be ignored.
    vecs.push_back(mk(0,1,32'h20,32'h12345678, 0,0,0,            1,0,0,0, 0,0, 32'hCAFEF00D));
    vecs.push_back(mk(0,1,32'h20,32'h12345678, 0,1,32'h0BAD0BAD, 1,0,1,1, 32'h20,32'h12345678, 32'hCAFEF00D));
    vecs.push_back(mk(0,1,32'h20,32'h12345678, 0,0,0,            1,0,1,1, 32'h20,32'h12345678, 32'hCAFEF00D));
    vecs.push_back(mk(0,1,32'h20,32'h12345678, 0,0,0,            1,0,1,1, 32'h20,32'h12345678, 32'hCAFEF00D));
    vecs.push_back(mk(0,1,32'h20,32'h12345678, 1,0,0,            1,0,1,1, 32'h20,32'h12345678, 32'hCAFEF00D));
    vecs.push_back(mk(0,1,32'h20,32'h12345678, 0,1,32'h0BAD0BAD, 0,0,0,0, 0,0, 32'hCAFEF00D));
    vecs.push_back(mk(0,0,32'h0,0,             0,0,0,            0,0,0,0, 0,0, 32'hCAFEF00D));
`endif
    // Misaligned accesses: flag only, no stall, no bus cycle, read data kept.
    vecs.push_back(mk(1,0,32'h22,0, 0,0,0,            0,1,0,0, 0,0, 32'hCAFEF00D));
    vecs.push_back(mk(1,0,32'h22,0, 1,1,32'h0BAD0BAD, 0,1,0,0, 0,0, 32'hCAFEF00D));
    vecs.push_back(mk(0,1,32'h21,0, 0,0,0,            0,1,0,0, 0,0, 32'hCAFEF00D));
    vecs.push_back(mk(0,1,32'h23,0, 0,0,0,            0,1,0,0, 0,0, 32'hCAFEF00D));
    vecs.push_back(mk(0,0,32'h22,0, 0,0,0,            0,0,0,0, 0,0, 32'hCAFEF00D));
`ifndef DMEM_POSTED_WRITE_EN
    // Read and write both high is treated as a write.
    vecs.push_back(mk(1,1,32'h30,32'hA5A5A5A5, 0,0,0, 1,0,0,0, 0,0, 32'hCAFEF00D));
    vecs.push_back(mk(1,1,32'h30,32'hA5A5A5A5, 1,0,0, 1,0,1,1, 32'h30,32'hA5A5A5A5, 32'hCAFEF00D));
    vecs.push_back(mk(1,1,32'h30,32'hA5A5A5A5, 0,0,0, 0,0,0,0, 0,0, 32'hCAFEF00D));
    vecs.push_back(mk(0,0,32'h0,0,             0,0,0, 0,0,0,0, 0,0, 32'hCAFEF00D));
`endif

    #3;
    checkOutput("reset_rdata", RData_o, 32'h0);
    checkOutput("reset_busreq", 32'(bus_if.BusReq_o), 32'd0);
    checkOutput("reset_buswe", 32'(bus_if.BusWe_o), 32'd0);
    checkOutput("reset_busaddr", bus_if.BusAddr_o, 32'h0);
    checkOutput("reset_buswdata", bus_if.BusWData_o, 32'h0);
    checkOutput("reset_terr", 32'(TimeoutErr_o), 32'd0);
    checkOutput("reset_stall", 32'(Stall_o), 32'd0);
    #20;
    Rst = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Load with the grant held low: abort after TIMEOUT_CYC cycles in REQ.
    drive(1,0,32'h40,0, 0,0,0);
    checkOutput("to_idle_stall", 32'(Stall_o), 32'd1);
    count = 0;
    seen  = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      drive(1,0,32'h40,0, 0,0,0);
      if (TimeoutErr_o) seen = 1'b1;
      else if (Stall_o && bus_if.BusReq_o) count++;
    end
    checkOutput("to_pulse_seen", 32'(seen), 32'd1);
    checkOutput("to_req_cycles", 32'(count), 32'd8);
    checkOutput("to_rdata", RData_o, 32'hDEADBEEF);
    checkOutput("to_done_stall", 32'(Stall_o), 32'd0);
    checkOutput("to_done_busreq", 32'(bus_if.BusReq_o), 32'd0);
    drive(0,0,0,0, 0,0,0);
    checkOutput("to_pulse_end", 32'(TimeoutErr_o), 32'd0);
    checkOutput("to_idle_after", 32'(Stall_o), 32'd0);

    // Reset while waiting for read data; a late response must be ignored.
    drive(1,0,32'h50,0, 0,0,0);
    drive(1,0,32'h50,0, 1,0,0);
    checkOutput("rst_req_addr", bus_if.BusAddr_o, 32'h50);
    drive(1,0,32'h50,0, 0,0,0);
    checkOutput("rst_wait_stall", 32'(Stall_o), 32'd1);
    #2;
    Rst       = 1'b0;
    MemRead_i = 1'b0;
    #1;
    checkOutput("rst_async_rdata", RData_o, 32'h0);
    checkOutput("rst_async_busreq", 32'(bus_if.BusReq_o), 32'd0);
    checkOutput("rst_async_busaddr", bus_if.BusAddr_o, 32'h0);
    checkOutput("rst_async_stall", 32'(Stall_o), 32'd0);
    drive(0,0,0,0, 0,1,32'h11111111);
    #2;
    Rst = 1'b1;
    drive(0,0,0,0, 0,1,32'h22222222);
    checkOutput("rst_late_rvalid", RData_o, 32'h0);
    drive(0,0,0,0, 0,0,0);
    checkOutput("rst_late_rdata", RData_o, 32'h0);
    checkOutput("rst_late_busreq", 32'(bus_if.BusReq_o), 32'd0);

`ifdef DMEM_POSTED_WRITE_EN
    // Posted store, then a load that waits for the two-cycle-delayed drain.
    drive(0,1,32'h60,32'h600DF00D, 0,0,0);
    checkOutput("pw_store_stall", 32'(Stall_o), 32'd0);
    drive(1,0,32'h10,0, 0,0,0);
    checkOutput("pw_drain_req", 32'(bus_if.BusReq_o), 32'd1);
    checkOutput("pw_drain_we", 32'(bus_if.BusWe_o), 32'd1);
    checkOutput("pw_drain_addr", bus_if.BusAddr_o, 32'h60);
    checkOutput("pw_drain_wdata", bus_if.BusWData_o, 32'h600DF00D);
    checkOutput("pw_drain_stall1", 32'(Stall_o), 32'd1);
    drive(1,0,32'h10,0, 0,0,0);
    checkOutput("pw_drain_stall2", 32'(Stall_o), 32'd1);
    drive(1,0,32'h10,0, 1,0,0);
    checkOutput("pw_drain_stall3", 32'(Stall_o), 32'd1);
    drive(1,0,32'h10,0, 0,0,0);
    checkOutput("pw_idle_stall", 32'(Stall_o), 32'd1);
    checkOutput("pw_idle_busreq", 32'(bus_if.BusReq_o), 32'd0);
    drive(1,0,32'h10,0, 1,0,0);
    checkOutput("pw_load_req", 32'(bus_if.BusReq_o), 32'd1);
    checkOutput("pw_load_we", 32'(bus_if.BusWe_o), 32'd0);
    checkOutput("pw_load_addr", bus_if.BusAddr_o, 32'h10);
    drive(1,0,32'h10,0, 0,1,32'h00000077);
    checkOutput("pw_wait_stall", 32'(Stall_o), 32'd1);
    drive(1,0,32'h10,0, 0,0,0);
    checkOutput("pw_done_stall", 32'(Stall_o), 32'd0);
    checkOutput("pw_done_rdata", RData_o, 32'h00000077);
    drive(0,0,0,0, 0,0,0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
